// File: rtl/cache_arbiter.sv
// Two-client (I-side / D-side) arbiter onto a single pmem line port with registered grant.
// Optional CACHE_ARB_RR_EN macro switches tie-breaking from fixed D-priority to round-robin.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_arb_mem_read,
  input  logic                  i_arb_mem_write,
  input  logic [ADDR_WIDTH-1:0] i_arb_mem_address,
  input  logic [LINE_WIDTH-1:0] i_arb_mem_wdata,
  output logic                  i_arb_mem_resp,
  output logic [LINE_WIDTH-1:0] i_arb_mem_rdata,
  input  logic                  d_arb_mem_read,
  input  logic                  d_arb_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_arb_mem_address,
  input  logic [LINE_WIDTH-1:0] d_arb_mem_wdata,
  output logic                  d_arb_mem_resp,
  output logic [LINE_WIDTH-1:0] d_arb_mem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a client holds read/write (plus address/wdata) until its resp pulse;
  // pmem_read/pmem_write are held from grant until the one-cycle pmem_resp, which ends the transaction.
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_grant;
  logic                  w_pick_d;
  logic                  w_busy;

  assign w_i_req = i_arb_mem_read | i_arb_mem_write;
  assign w_d_req = d_arb_mem_read | d_arb_mem_write;

`ifdef CACHE_ARB_RR_EN
  // 1 = D-side held the most recent grant; reset favours D on the first tie.
  logic r_last_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last_d <= 1'b0;
    else if (w_grant) r_last_d <= w_pick_d;
  end
  assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
`else
  assign w_pick_d = w_d_req;
`endif

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req | w_d_req) begin
          w_grant = 1'b1;
          w_next  = w_pick_d ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        // A write wins over a read if a client illegally raises both.
        r_op_write <= w_pick_d ? d_arb_mem_write   : i_arb_mem_write;
        r_addr     <= w_pick_d ? d_arb_mem_address : i_arb_mem_address;
        r_wdata    <= w_pick_d ? d_arb_mem_wdata   : i_arb_mem_wdata;
      end
    end
  end

  assign w_busy       = (r_state == GRANT_I) | (r_state == GRANT_D);
  assign pmem_read    = w_busy & ~r_op_write;
  assign pmem_write   = w_busy & r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign o_dbg_state  = r_state;

  // A client that has withdrawn its request does not receive the completion.
  assign i_arb_mem_resp  = pmem_resp & (r_state == GRANT_I) & w_i_req;
  assign d_arb_mem_resp  = pmem_resp & (r_state == GRANT_D) & w_d_req;
  assign i_arb_mem_rdata = (r_state == GRANT_I) ? pmem_rdata : '0;
  assign d_arb_mem_rdata = (r_state == GRANT_D) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of the grant policy.
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_arb_mem_read = 1'b0, i_arb_mem_write = 1'b0;
  logic [15:0]  i_arb_mem_address = '0;
  logic [127:0] i_arb_mem_wdata = '0;
  logic         i_arb_mem_resp;
  logic [127:0] i_arb_mem_rdata;
  logic         d_arb_mem_read = 1'b0, d_arb_mem_write = 1'b0;
  logic [15:0]  d_arb_mem_address = '0;
  logic [127:0] d_arb_mem_wdata = '0;
  logic         d_arb_mem_resp;
  logic [127:0] d_arb_mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [1:0]   o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: pending requests per client and who was granted last.
  bit           pend_i, pend_d, last_d;
  logic [1:0]   op_i, op_d;           // bit0 = read, bit1 = write
  logic [15:0]  addr_i, addr_d;
  logic [127:0] wd_i, wd_d;

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .i_arb_mem_read(i_arb_mem_read), .i_arb_mem_write(i_arb_mem_write),
    .i_arb_mem_address(i_arb_mem_address), .i_arb_mem_wdata(i_arb_mem_wdata),
    .i_arb_mem_resp(i_arb_mem_resp), .i_arb_mem_rdata(i_arb_mem_rdata),
    .d_arb_mem_read(d_arb_mem_read), .d_arb_mem_write(d_arb_mem_write),
    .d_arb_mem_address(d_arb_mem_address), .d_arb_mem_wdata(d_arb_mem_wdata),
    .d_arb_mem_resp(d_arb_mem_resp), .d_arb_mem_rdata(d_arb_mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_client(input bit is_d, input logic [1:0] op, input logic [15:0] a,
                            input logic [127:0] w);
    if (is_d) begin
      d_arb_mem_read = op[0]; d_arb_mem_write = op[1];
      d_arb_mem_address = a;  d_arb_mem_wdata = w;
      op_d = op; addr_d = a; wd_d = w; pend_d = (op != 2'b00);
    end else begin
      i_arb_mem_read = op[0]; i_arb_mem_write = op[1];
      i_arb_mem_address = a;  i_arb_mem_wdata = w;
      op_i = op; addr_i = a; wd_i = w; pend_i = (op != 2'b00);
    end
  endtask

  function automatic bit model_pick_d();
`ifdef CACHE_ARB_RR_EN
    if (pend_i && pend_d) return !last_d;
`endif
    return pend_d;
  endfunction

  // Serves the transaction the model says is granted next; called at a negedge
  // with requests already driven, returns at the negedge of the separating IDLE cycle.
  task automatic serve_one(input bit drop_mid, input int dly, input logic [127:0] line);
    bit           win_d;
    bit           exp_wr;
    logic [15:0]  exp_a;
    logic [127:0] exp_w, rd;
    win_d  = model_pick_d();
    last_d = win_d;
    exp_wr = win_d ? op_d[1] : op_i[1];
    exp_a  = win_d ? addr_d : addr_i;
    exp_w  = win_d ? wd_d : wd_i;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write} !== {!exp_wr, exp_wr}) begin
      n_err++; $display("FAIL grant_op: got r=%b w=%b want w=%b", pmem_read, pmem_write, exp_wr);
    end
    n_cmp++;
    if (pmem_address !== exp_a || pmem_wdata !== exp_w) begin
      n_err++; $display("FAIL grant_addr: got %h/%h want %h/%h", pmem_address, pmem_wdata, exp_a, exp_w);
    end
    // Client changes its inputs mid-transaction; pmem must keep the latched copy.
    if (win_d) begin
      d_arb_mem_address = 16'h9999; d_arb_mem_wdata = ~wd_d;
      if (drop_mid) begin d_arb_mem_read = 1'b0; d_arb_mem_write = 1'b0; end
    end else begin
      i_arb_mem_address = 16'h9999; i_arb_mem_wdata = ~wd_i;
      if (drop_mid) begin i_arb_mem_read = 1'b0; i_arb_mem_write = 1'b0; end
    end
    for (int k = 0; k < dly; k++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      pmem_rdata = rd;
      #1;
      n_cmp++;
      if (pmem_address !== exp_a || pmem_wdata !== exp_w || pmem_write !== exp_wr || pmem_read !== !exp_wr) begin
        n_err++; $display("FAIL hold: got a=%h r=%b w=%b want a=%h w=%b", pmem_address, pmem_read, pmem_write, exp_a, exp_wr);
      end
      n_cmp++;
      if (i_arb_mem_resp !== 1'b0 || d_arb_mem_resp !== 1'b0 ||
          (win_d ? d_arb_mem_rdata : i_arb_mem_rdata) !== rd ||
          (win_d ? i_arb_mem_rdata : d_arb_mem_rdata) !== 128'h0) begin
        n_err++; $display("FAIL wait_resp: got i=%b d=%b irdata=%h drdata=%h want no resp, rdata to %s",
                          i_arb_mem_resp, d_arb_mem_resp, i_arb_mem_rdata, d_arb_mem_rdata, win_d ? "D" : "I");
      end
      @(negedge clk);
    end
    pmem_resp = 1'b1; pmem_rdata = line;
    #1;
    n_cmp++;
    if ((win_d ? d_arb_mem_resp : i_arb_mem_resp) !== !drop_mid ||
        (win_d ? i_arb_mem_resp : d_arb_mem_resp) !== 1'b0) begin
      n_err++; $display("FAIL resp: got i=%b d=%b want %s=%b other 0", i_arb_mem_resp, d_arb_mem_resp,
                        win_d ? "D" : "I", !drop_mid);
    end
    n_cmp++;
    if ((win_d ? d_arb_mem_rdata : i_arb_mem_rdata) !== line ||
        (win_d ? i_arb_mem_rdata : d_arb_mem_rdata) !== 128'h0) begin
      n_err++; $display("FAIL resp_data: got i=%h d=%h want %h to %s", i_arb_mem_rdata, d_arb_mem_rdata,
                        line, win_d ? "D" : "I");
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    set_client(win_d, 2'b00, 16'h0, 128'h0);
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || o_dbg_state !== 2'd0) begin
      n_err++; $display("FAIL idle_gap: got r=%b w=%b st=%0d want 0 0 0", pmem_read, pmem_write, o_dbg_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pmem_read, pmem_write, i_arb_mem_resp, d_arb_mem_resp} !== 4'b0 || pmem_address !== 16'h0 ||
        pmem_wdata !== 128'h0 || i_arb_mem_rdata !== 128'h0 || d_arb_mem_rdata !== 128'h0 || o_dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset: got r=%b w=%b a=%h st=%0d want all 0", pmem_read, pmem_write, pmem_address, o_dbg_state);
    end
    last_d = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // pmem_resp while IDLE must not reach a client.
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (i_arb_mem_resp !== 1'b0 || d_arb_mem_resp !== 1'b0 || o_dbg_state !== 2'd0) begin
      n_err++; $display("FAIL idle_resp: got i=%b d=%b st=%0d want 0 0 0", i_arb_mem_resp, d_arb_mem_resp, o_dbg_state);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  task automatic test_single_read();
    set_client(1'b0, 2'b01, 16'h1230, 128'h0);
    serve_one(1'b0, 5, {16{8'hA5}});
  endtask

  task automatic test_tie();
    set_client(1'b0, 2'b01, 16'h0040, 128'h0);
    set_client(1'b1, 2'b10, 16'h8000, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
    serve_one(1'b0, 2, 128'h1111);
    serve_one(1'b0, 3, 128'h2222);
  endtask

  task automatic test_addr_change();
    set_client(1'b1, 2'b10, 16'h2468, 128'h0BAD_F00D);
    serve_one(1'b0, 4, 128'h0);
  endtask

  task automatic test_drop();
    set_client(1'b0, 2'b01, 16'h0777, 128'h0);
    serve_one(1'b1, 3, 128'h5A5A);
  endtask

  task automatic test_illegal_both();
    set_client(1'b0, 2'b11, 16'h0C00, 128'h1357_9BDF);
    serve_one(1'b0, 1, 128'h77);
  endtask

  task automatic test_back_to_back();
    bit served_d;
    set_client(1'b0, 2'b01, 16'h1000, 128'h0);
    set_client(1'b1, 2'b01, 16'h2000, 128'h0);
    for (int t = 0; t < 4; t++) begin
      served_d = model_pick_d();
      serve_one(1'b0, $urandom_range(1, 3), {4{$urandom()}});
      if (t < 3) set_client(served_d, 2'b01, served_d ? 16'h2000 + 16'(t) : 16'h1000 + 16'(t), 128'h0);
    end
    // Withdraw whatever is still pending before the next scenario.
    set_client(1'b0, 2'b00, 16'h0, 128'h0);
    set_client(1'b1, 2'b00, 16'h0, 128'h0);
    @(negedge clk);
  endtask

  task automatic test_random();
    int mask;
    for (int r = 0; r < 15; r++) begin
      mask = $urandom_range(1, 3);
      if (mask[0]) set_client(1'b0, 2'($urandom_range(1, 3)), 16'($urandom()), {4{$urandom()}});
      if (mask[1]) set_client(1'b1, 2'($urandom_range(1, 3)), 16'($urandom()), {4{$urandom()}});
      while (pend_i || pend_d) serve_one(1'b0, $urandom_range(1, 5), {4{$urandom()}});
    end
  endtask

  task automatic test_reset_mid();
    set_client(1'b1, 2'b10, 16'h4000, 128'hFACE);
    @(negedge clk);
    n_cmp++;
    if (pmem_write !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: got w=%b want 1", pmem_write);
    end
    #2 rst = 1'b1;
    set_client(1'b1, 2'b00, 16'h0, 128'h0);
    last_d = 1'b0;
    #1;
    n_cmp++;
    if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || o_dbg_state !== 2'd0) begin
      n_err++; $display("FAIL rst_async: got r=%b w=%b st=%0d want 0 0 0", pmem_read, pmem_write, o_dbg_state);
    end
    @(negedge clk);
    rst = 1'b0; pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (i_arb_mem_resp !== 1'b0 || d_arb_mem_resp !== 1'b0) begin
      n_err++; $display("FAIL rst_late_resp: got i=%b d=%b want 0 0", i_arb_mem_resp, d_arb_mem_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_addr_change();
    test_drop();
    test_illegal_both();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_single_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
